// File: rtl/pc_sequencer_if.sv
// Fetch and dispatch bus between the front-end sequencer (master) and the
// instruction memory / execute stage (slave).
interface pc_sequencer_if #(
   parameter int DW = 16
);
   logic          fetch_req;
   logic [DW-1:0] fetch_addr;
   logic          fetch_ack;
   logic [DW-1:0] fetch_data;
   logic          dispatch_valid;
   logic          dispatch_ready;
   logic [DW-1:0] dispatch_instr;
   logic [DW-1:0] dispatch_imm;
   logic [DW-1:0] rd_data;
   logic          cond;

   modport master (
      output fetch_req, fetch_addr, dispatch_valid, dispatch_instr, dispatch_imm,
      input  fetch_ack, fetch_data, dispatch_ready, rd_data, cond
   );

   modport slave (
      input  fetch_req, fetch_addr, dispatch_valid, dispatch_instr, dispatch_imm,
      output fetch_ack, fetch_data, dispatch_ready, rd_data, cond
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/dispatch sequencer: registered PC, one- and two-word
// instruction fetch, hardware control flow and a return-address stack.
module pc_sequencer #(
   parameter int            DW       = 16,
   parameter int            RS_DEPTH = 8,
   parameter logic [DW-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   pc_sequencer_if.master            bus,
   output logic [DW-1:0]             pc,
   output logic                      halted,
   output logic [$clog2(RS_DEPTH):0] rs_count,
   output logic                      rs_overflow,
   output logic                      rs_underflow
);
   localparam int          AW      = $clog2(RS_DEPTH);
   localparam logic [AW:0] RS_FULL = (AW+1)'(RS_DEPTH);

   localparam logic [4:0] OP_CALL = 5'b00001;
   localparam logic [4:0] OP_JMPR = 5'b00100;
   localparam logic [4:0] OP_JMPI = 5'b00101;
   localparam logic [4:0] OP_RTN  = 5'b11100;
   localparam logic [4:0] OP_STP  = 5'b11111;

   typedef enum logic [1:0] {S_FETCH, S_IMM, S_ISSUE, S_HALT} state_t;

   state_t        state, state_nx;
   logic          fetch_req_q, dispatch_valid_q;
   logic [DW-1:0] instr_q, imm_q;
   logic [DW-1:0] rs_mem [RS_DEPTH];
   logic          fetch_take, issue_take;
   logic [4:0]    op;
   logic          rs_full, rs_empty, rs_push;
   logic [AW-1:0] rs_top;

   function automatic logic is_two_word(input logic [4:0] opc);
      case (opc)
         5'b00001, 5'b00101, 5'b01001, 5'b01011,
         5'b01101, 5'b01111, 5'b10111: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   assign op       = instr_q[15:11];
   assign rs_full  = (rs_count == RS_FULL);
   assign rs_empty = (rs_count == '0);
   assign rs_top   = rs_count[AW-1:0] - AW'(1);
   assign rs_push  = issue_take && (op == OP_CALL) && !rs_full;

   assign bus.fetch_req      = fetch_req_q;
   assign bus.fetch_addr     = pc;
   assign bus.dispatch_valid = dispatch_valid_q;
   assign bus.dispatch_instr = instr_q;
   assign bus.dispatch_imm   = imm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // An acknowledge only counts while a request is actually outstanding.
   always_comb begin
      state_nx   = state;
      fetch_take = 1'b0;
      issue_take = 1'b0;
      case (state)
         S_FETCH: if (fetch_req_q && bus.fetch_ack) begin
            fetch_take = 1'b1;
            state_nx   = is_two_word(bus.fetch_data[15:11]) ? S_IMM : S_ISSUE;
         end
         S_IMM: if (fetch_req_q && bus.fetch_ack) begin
            fetch_take = 1'b1;
            state_nx   = S_ISSUE;
         end
         S_ISSUE: if (dispatch_valid_q && bus.dispatch_ready) begin
            issue_take = 1'b1;
            state_nx   = (op == OP_STP) ? S_HALT : S_FETCH;
         end
         default: state_nx = state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc               <= RESET_PC;
         fetch_req_q      <= 1'b0;
         dispatch_valid_q <= 1'b0;
         instr_q          <= '0;
         imm_q            <= '0;
         halted           <= 1'b0;
         rs_count         <= '0;
         rs_overflow      <= 1'b0;
         rs_underflow     <= 1'b0;
      end else begin
         fetch_req_q      <= (state_nx == S_FETCH) || (state_nx == S_IMM);
         dispatch_valid_q <= (state_nx == S_ISSUE);
         halted           <= (state_nx == S_HALT);
         if (fetch_take) begin
            pc <= pc + DW'(1);
            if (state == S_FETCH) begin
               instr_q <= bus.fetch_data;
               imm_q   <= '0;
            end else begin
               imm_q   <= bus.fetch_data;
            end
         end
         // pc already points past the instruction when the action is applied.
         if (issue_take) begin
            casez (op)
               OP_CALL: begin
                  pc <= imm_q;
                  if (rs_full) rs_overflow <= 1'b1;
                  else         rs_count    <= rs_count + (AW+1)'(1);
               end
               OP_RTN: begin
                  if (rs_empty) begin
                     pc           <= RESET_PC;
                     rs_underflow <= 1'b1;
                  end else begin
                     pc       <= rs_mem[rs_top];
                     rs_count <= rs_count - (AW+1)'(1);
                  end
               end
               OP_JMPR:  pc <= bus.rd_data;
               OP_JMPI:  pc <= imm_q;
               5'b0001?: if (bus.cond) pc <= pc + DW'(instr_q[1:0]);
               default:  pc <= pc;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rs_push) rs_mem[rs_count[AW-1:0]] <= pc;
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a program table replayed through a fetch responder,
// with a dispatch scoreboard and hand-written reset/halt sequences.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc;
   logic        halted;
   logic [3:0]  rs_count;
   logic        rs_overflow, rs_underflow;

   pc_sequencer_if #(.DW(16)) bus ();

   pc_sequencer #(.DW(16), .RS_DEPTH(8), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .pc           (pc),
      .halted       (halted),
      .rs_count     (rs_count),
      .rs_overflow  (rs_overflow),
      .rs_underflow (rs_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] instr;
      bit          tw;
      logic [15:0] imm;
      logic [15:0] rd;
      bit          c;
      int          stall;
      logic [15:0] nxt;
      int          rs;
      bit          ovf;
      bit          unf;
      bit          hlt;
   } vec_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] imm;
   } exp_t;

   vec_t prog[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   seg_split;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic [15:0] a, input logic [15:0] ins, input bit tw,
                               input logic [15:0] im, input logic [15:0] rd, input bit c,
                               input int st, input logic [15:0] nx, input int rs,
                               input bit ov, input bit un, input bit hl);
      vec_t v;
      v.addr = a;  v.instr = ins; v.tw = tw; v.imm = im; v.rd = rd; v.c = c;
      v.stall = st; v.nxt = nx; v.rs = rs; v.ovf = ov; v.unf = un; v.hlt = hl;
      prog.push_back(v);
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_fetch_req"}, 32'(bus.fetch_req), 0);
      chk({tag, "_fetch_addr"}, 32'(bus.fetch_addr), 0);
      chk({tag, "_valid"}, 32'(bus.dispatch_valid), 0);
      chk({tag, "_instr"}, 32'(bus.dispatch_instr), 0);
      chk({tag, "_imm"}, 32'(bus.dispatch_imm), 0);
      chk({tag, "_pc"}, 32'(pc), 0);
      chk({tag, "_halted"}, 32'(halted), 0);
      chk({tag, "_rs_count"}, 32'(rs_count), 0);
      chk({tag, "_ovf"}, 32'(rs_overflow), 0);
      chk({tag, "_unf"}, 32'(rs_underflow), 0);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      exp_t e;
      int   n;
      v = prog[i];
      n = 0;
      while (!bus.fetch_req && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("v%0d_fetch_wait", i), 32'(n), 0);
      for (int k = 0; k < v.stall; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d_req_hold", i), 32'(bus.fetch_req), 1);
         chk($sformatf("v%0d_addr_hold", i), 32'(bus.fetch_addr), 32'(v.addr));
      end
      chk($sformatf("v%0d_addr", i), 32'(bus.fetch_addr), 32'(v.addr));
      sb.push_back('{v.instr, v.tw ? v.imm : 16'h0000});
      bus.fetch_data = v.instr;
      bus.fetch_ack  = 1'b1;
      @(negedge clk);
      bus.fetch_ack  = 1'b0;
      if (v.tw) begin
         chk($sformatf("v%0d_imm_req", i), 32'(bus.fetch_req), 1);
         chk($sformatf("v%0d_imm_addr", i), 32'(bus.fetch_addr), 32'(v.addr + 16'd1));
         bus.fetch_data = v.imm;
         bus.fetch_ack  = 1'b1;
         @(negedge clk);
         bus.fetch_ack  = 1'b0;
      end
      n = 0;
      while (!bus.dispatch_valid && n < 20) begin @(negedge clk); n++; end
      chk($sformatf("v%0d_disp_latency", i), 32'(n), 0);
      e = sb.pop_front();
      chk($sformatf("v%0d_instr", i), 32'(bus.dispatch_instr), 32'(e.instr));
      chk($sformatf("v%0d_imm", i), 32'(bus.dispatch_imm), 32'(e.imm));
      // Stray acknowledges while nothing is requested must not disturb the held instruction.
      bus.fetch_data = 16'hDEAD;
      for (int k = 0; k < v.stall; k++) begin
         bus.fetch_ack = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_stall_valid", i), 32'(bus.dispatch_valid), 1);
         chk($sformatf("v%0d_stall_instr", i), 32'(bus.dispatch_instr), 32'(e.instr));
         chk($sformatf("v%0d_stall_imm", i), 32'(bus.dispatch_imm), 32'(e.imm));
         chk($sformatf("v%0d_stall_req", i), 32'(bus.fetch_req), 0);
      end
      bus.fetch_ack      = 1'b0;
      bus.dispatch_ready = 1'b1;
      bus.rd_data        = v.rd;
      bus.cond           = v.c;
      @(negedge clk);
      bus.dispatch_ready = 1'b0;
      bus.rd_data        = 16'h5A5A;
      bus.cond           = ~v.c;
      chk($sformatf("v%0d_valid_drop", i), 32'(bus.dispatch_valid), 0);
      chk($sformatf("v%0d_next_pc", i), 32'(pc), 32'(v.nxt));
      chk($sformatf("v%0d_next_addr", i), 32'(bus.fetch_addr), 32'(v.nxt));
      chk($sformatf("v%0d_rs_count", i), 32'(rs_count), 32'(v.rs));
      chk($sformatf("v%0d_ovf", i), 32'(rs_overflow), 32'(v.ovf));
      chk($sformatf("v%0d_unf", i), 32'(rs_underflow), 32'(v.unf));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v.hlt));
      chk($sformatf("v%0d_req_after", i), 32'(bus.fetch_req), 32'(!v.hlt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Program in execution order: address, word(s), handshake inputs, expected result.
      add(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 0, 0, 0);
      add(16'h0001, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0002, 0, 0, 0, 0);
      add(16'h0002, 16'h2800, 1, 16'h0010, 16'h0000, 0, 0, 16'h0010, 0, 0, 0, 0);
      add(16'h0010, 16'h0800, 1, 16'h0040, 16'h0000, 0, 0, 16'h0040, 1, 0, 0, 0);
      add(16'h0040, 16'hE000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0012, 0, 0, 0, 0);
      add(16'h0012, 16'h2800, 1, 16'h0005, 16'h0000, 0, 0, 16'h0005, 0, 0, 0, 0);
      add(16'h0005, 16'h1002, 0, 16'h0000, 16'h0000, 1, 0, 16'h0008, 0, 0, 0, 0);
      add(16'h0008, 16'h2800, 1, 16'h0005, 16'h0000, 0, 0, 16'h0005, 0, 0, 0, 0);
      add(16'h0005, 16'h1002, 0, 16'h0000, 16'h0000, 0, 0, 16'h0006, 0, 0, 0, 0);
      add(16'h0006, 16'h1803, 0, 16'h0000, 16'h0000, 1, 0, 16'h000A, 0, 0, 0, 0);
      add(16'h000A, 16'h2000, 0, 16'h0000, 16'hFFFF, 0, 3, 16'hFFFF, 0, 0, 0, 0);
      add(16'hFFFF, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0);
      for (int k = 0; k <= 8; k++)
         add(16'(k * 256), 16'h0800, 1, 16'((k + 1) * 256), 16'h0000, 0, 0,
             16'((k + 1) * 256), (k + 1 > 8) ? 8 : k + 1, k == 8, 0, 0);
      for (int j = 1; j <= 9; j++)
         add((j == 1) ? 16'h0900 : 16'((9 - j) * 256 + 2), 16'hE000, 0, 16'h0000, 16'h0000, 0, 0,
             (j == 9) ? 16'h0000 : 16'((8 - j) * 256 + 2), (j == 9) ? 0 : 8 - j, 1, j == 9, 0);
      add(16'h0000, 16'hF800, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 1, 1, 1);
      seg_split = prog.size();
      add(16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0001, 0, 0, 0, 0);

      rst_n = 1'b0;
      bus.fetch_ack = 1'b0;  bus.fetch_data = 16'h0000;
      bus.dispatch_ready = 1'b0;  bus.rd_data = 16'h0000;  bus.cond = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      chk("rst_release_req", 32'(bus.fetch_req), 0);
      @(negedge clk);
      chk("first_req", 32'(bus.fetch_req), 1);
      chk("first_addr", 32'(bus.fetch_addr), 0);

      for (int i = 0; i < seg_split; i++) run_vec(i);

      bus.fetch_data = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         bus.fetch_ack = 1'b1;
         @(negedge clk);
         chk("halt_req", 32'(bus.fetch_req), 0);
         chk("halt_valid", 32'(bus.dispatch_valid), 0);
         chk("halt_flag", 32'(halted), 1);
         chk("halt_pc", 32'(pc), 1);
      end
      bus.fetch_ack = 1'b0;

      rst_n = 1'b0;
      #1;
      check_reset("rst_halt");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("re_req", 32'(bus.fetch_req), 1);
      bus.fetch_data = 16'h0800;
      bus.fetch_ack  = 1'b1;
      @(negedge clk);
      chk("midimm_req", 32'(bus.fetch_req), 1);
      chk("midimm_addr", 32'(bus.fetch_addr), 1);
      bus.fetch_data = 16'h0123;
      rst_n = 1'b0;
      #1;
      check_reset("rst_imm");
      @(negedge clk);
      check_reset("rst_imm_hold");
      bus.fetch_ack = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = seg_split; i < prog.size(); i++) run_vec(i);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
